// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory bus between the fetch stage
// and the memory stage. One access at a time, registered bus outputs,
// alternating priority under contention, fetch discard on flush and a
// bounded wait on every bus access.
//
// Timeout behaviour: the counter holds the number of BUSY cycles already
// spent without bus_ack. The access is forced to complete in the BUSY cycle
// where that count would reach TIMEOUT, so bus_req is high for at most
// TIMEOUT cycles without an ack. A real bus_ack in that same cycle wins and
// completes normally with its data.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic [3:0]  dm_wstrb_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        timeout_o
);

    localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;   // 0 = fetch, 1 = data
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;
    logic          bus_req_q, bus_req_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;

    logic fetch_ok;
    logic gnt_dm;
    logic gnt_if;
    logic busy;
    logic tmo_hit;
    logic done;
    logic fetch_dropped;

    // Grant selection in IDLE and completion detection in BUSY.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        fetch_ok = if_req_i & ~flush_i;
        gnt_dm   = 1'b0;
        gnt_if   = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req_i && (!fetch_ok || !last_gnt_q)) begin
                gnt_dm = 1'b1;
            end else if (fetch_ok) begin
                gnt_if = 1'b1;
            end
        end
        busy          = (state_q != IDLE);
        tmo_hit       = busy && !bus_ack_i && (cnt_q == CNT_LAST);
        done          = busy && (bus_ack_i || tmo_hit);
        // A flush coinciding with completion also discards the fetch.
        fetch_dropped = drop_q | flush_i;
    end

    // State register and bus registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Next-state and next bus-register values.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_dm) begin
                    state_d     = DM_BUSY;
                    last_gnt_d  = 1'b1;
                    cnt_d       = '0;
                    drop_d      = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = dm_addr_i;
                    bus_wstrb_d = dm_wstrb_i;
                    bus_wdata_d = dm_wdata_i;
                end else if (gnt_if) begin
                    state_d     = IF_BUSY;
                    last_gnt_d  = 1'b0;
                    cnt_d       = '0;
                    drop_d      = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = if_addr_i;
                    bus_wstrb_d = '0;
                    bus_wdata_d = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (done) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    drop_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (state_q == IF_BUSY && flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route completion to the owning stage; data is zero unless acked.
    always_comb begin
        if_ack_o   = 1'b0;
        if_rdata_o = '0;
        dm_ack_o   = 1'b0;
        dm_rdata_o = '0;
        timeout_o  = tmo_hit;
        if (done && state_q == IF_BUSY && !fetch_dropped) begin
            if_ack_o   = 1'b1;
            if_rdata_o = bus_ack_i ? bus_rdata_i : '0;
        end
        if (done && state_q == DM_BUSY) begin
            dm_ack_o   = 1'b1;
            dm_rdata_o = bus_ack_i ? bus_rdata_i : '0;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign bus_wdata_o = bus_wdata_q;
    assign stall_if_o  = if_req_i & ~if_ack_o;
    assign stall_mem_o = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        flush;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Bus responder controls: fix_wait < 0 picks a random wait per access.
    int          fix_wait    = 0;
    bit          fix_data_en = 0;
    logic [31:0] fix_data    = '0;
    bit          spur_en     = 0;
    int          rsp_cnt     = 0;
    int          cur_wait    = 0;
    logic [31:0] cur_data    = '0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_ack_o   (if_ack),
        .if_rdata_o (if_rdata),
        .dm_req_i   (dm_req),
        .dm_addr_i  (dm_addr),
        .dm_wstrb_i (dm_wstrb),
        .dm_wdata_i (dm_wdata),
        .dm_ack_o   (dm_ack),
        .dm_rdata_o (dm_rdata),
        .flush_i    (flush),
        .bus_req_o  (bus_req),
        .bus_addr_o (bus_addr),
        .bus_wstrb_o(bus_wstrb),
        .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack),
        .stall_if_o (stall_if),
        .stall_mem_o(stall_mem),
        .timeout_o  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus slave: acks k cycles after bus_req rises; optional stray acks when idle.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus_req) begin
                rsp_cnt   = 0;
                bus_ack   = spur_en && ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom;
            end else begin
                if (rsp_cnt == 0) begin
                    cur_wait = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 5));
                    cur_data = fix_data_en ? fix_data : $urandom;
                end
                bus_ack   = (rsp_cnt == cur_wait);
                bus_rdata = bus_ack ? cur_data : $urandom;
                rsp_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end, required end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_addr  = '0;
        dm_wstrb = '0;
        dm_wdata = '0;
        flush    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fix_wait = 0;
        do_reset();
        sample();
        checks++;
        if ({bus_req, bus_addr, bus_wstrb, bus_wdata} !== 69'd0) begin
            errors++;
            $display("FAIL reset_bus got %0h required 0", {bus_req, bus_addr, bus_wstrb, bus_wdata});
        end
        checks++;
        if ({if_ack, if_rdata, dm_ack, dm_rdata, timeout} !== 67'd0) begin
            errors++;
            $display("FAIL reset_acks got %0h required 0", {if_ack, if_rdata, dm_ack, dm_rdata, timeout});
        end
        checks++;
        if ({stall_if, stall_mem} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall got %b required 00", {stall_if, stall_mem});
        end
    endtask

    task automatic test_zero_wait();
        fix_wait    = 0;
        fix_data_en = 1;
        fix_data    = 32'h0000_0013;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h8000_0000;
        sample();
        checks++;
        if ({stall_if, bus_req, if_ack} !== 3'b100) begin
            errors++;
            $display("FAIL zw_c0 stall/req/ack got %b required 100", {stall_if, bus_req, if_ack});
        end
        tick();
        sample();
        checks++;
        if ({bus_req, bus_addr, bus_wstrb} !== {1'b1, 32'h8000_0000, 4'h0}) begin
            errors++;
            $display("FAIL zw_c1_bus got %0h required %0h", {bus_req, bus_addr, bus_wstrb}, {1'b1, 32'h8000_0000, 4'h0});
        end
        checks++;
        if ({if_ack, if_rdata, stall_if} !== {1'b1, 32'h13, 1'b0}) begin
            errors++;
            $display("FAIL zw_c1_ack got %0h required %0h", {if_ack, if_rdata, stall_if}, {1'b1, 32'h13, 1'b0});
        end
        tick();
        if_req = 1'b0;
        sample();
        checks++;
        if ({bus_req, if_ack, if_rdata, stall_if} !== 35'd0) begin
            errors++;
            $display("FAIL zw_c2 got %0h required 0", {bus_req, if_ack, if_rdata, stall_if});
        end
        fix_data_en = 0;
    endtask

    task automatic test_contention();
        fix_wait = 2;
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            if (c == 0) begin
                if_req   = 1'b1;
                if_addr  = 32'h8000_0040;
                dm_req   = 1'b1;
                dm_addr  = 32'h0000_0100;
                dm_wstrb = 4'hF;
                dm_wdata = 32'hDEAD_BEEF;
            end
            if (c == 4) dm_req = 1'b0;
            sample();
            checks++;
            if ({bus_req, dm_ack, if_ack, stall_mem, stall_if} !==
                {((c >= 1 && c <= 3) || c >= 5), c == 3, c == 7, c < 3, c < 7}) begin
                errors++;
                $display("FAIL cont_c%0d req/dack/iack/stm/sti got %b required %b", c,
                         {bus_req, dm_ack, if_ack, stall_mem, stall_if},
                         {((c >= 1 && c <= 3) || c >= 5), c == 3, c == 7, c < 3, c < 7});
            end
            if (c == 1) begin
                checks++;
                if ({bus_addr, bus_wstrb, bus_wdata} !== {32'h100, 4'hF, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL cont_store_bus got %0h required %0h", {bus_addr, bus_wstrb, bus_wdata}, {32'h100, 4'hF, 32'hDEAD_BEEF});
                end
            end
            if (c == 5) begin
                checks++;
                if ({bus_addr, bus_wstrb, bus_wdata} !== {32'h8000_0040, 4'h0, 32'h0}) begin
                    errors++;
                    $display("FAIL cont_fetch_bus got %0h required %0h", {bus_addr, bus_wstrb, bus_wdata}, {32'h8000_0040, 4'h0, 32'h0});
                end
            end
            tick();
        end
        if_req = 1'b0;
    endtask

    task automatic test_fairness();
        int grants;
        fix_wait = 0;
        do_reset();
        grants   = 0;
        if_req   = 1'b1;
        if_addr  = 32'h8000_0100;
        dm_req   = 1'b1;
        dm_addr  = 32'h0000_0200;
        dm_wstrb = 4'h0;
        for (int c = 0; c < 30 && grants < 6; c++) begin
            sample();
            if (if_ack || dm_ack) begin
                checks++;
                if (dm_ack !== (grants % 2 == 0) || if_ack === dm_ack) begin
                    errors++;
                    $display("FAIL fair_grant%0d got d=%b f=%b required d=%0d", grants, dm_ack, if_ack, grants % 2 == 0);
                end
                grants++;
            end
            tick();
        end
        checks++;
        if (grants != 6) begin
            errors++;
            $display("FAIL fair_count got %0d required 6 within budget", grants);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic test_flush();
        fix_wait = 3;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h8000_0200;
            end
            if (c == 2) flush = 1'b1;
            if (c == 3) begin
                flush   = 1'b0;
                if_addr = 32'h8000_0300;
            end
            sample();
            checks++;
            if ({bus_req, if_ack} !== {((c >= 1 && c <= 4) || c >= 6), c == 9}) begin
                errors++;
                $display("FAIL flush_c%0d req/ack got %b required %b", c, {bus_req, if_ack},
                         {((c >= 1 && c <= 4) || c >= 6), c == 9});
            end
            if (c == 6) begin
                checks++;
                if (bus_addr !== 32'h8000_0300) begin
                    errors++;
                    $display("FAIL flush_refetch_addr got %0h required 80000300", bus_addr);
                end
            end
            if (c == 9) begin
                checks++;
                if (if_rdata !== cur_data) begin
                    errors++;
                    $display("FAIL flush_refetch_data got %0h required %0h", if_rdata, cur_data);
                end
            end
            tick();
        end
        if_req = 1'b0;
    endtask

    task automatic test_timeout();
        fix_wait = 1000;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) begin
                dm_req   = 1'b1;
                dm_addr  = 32'h0000_0200;
                dm_wstrb = 4'h0;
            end
            if (c == 5) dm_req = 1'b0;
            sample();
            checks++;
            if ({bus_req, timeout, dm_ack, dm_rdata} !== {(c >= 1 && c <= 4), c == 4, c == 4, 32'h0}) begin
                errors++;
                $display("FAIL tmo_c%0d req/tmo/ack/rdata got %0h required %0h", c,
                         {bus_req, timeout, dm_ack, dm_rdata}, {(c >= 1 && c <= 4), c == 4, c == 4, 32'h0});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        fix_wait = 1000;
        do_reset();
        dm_req   = 1'b1;
        dm_addr  = 32'h0000_0300;
        dm_wstrb = 4'h3;
        dm_wdata = 32'h0000_1234;
        tick();
        sample();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_busy got %b required 1", bus_req);
        end
        tick();
        rst = 1'b1;
        sample();
        tick();
        sample();
        checks++;
        if ({bus_req, bus_addr, bus_wstrb, bus_wdata, dm_ack, timeout} !== 71'd0) begin
            errors++;
            $display("FAIL rmid_clear got %0h required 0", {bus_req, bus_addr, bus_wstrb, bus_wdata, dm_ack, timeout});
        end
        tick();
        rst      = 1'b0;
        dm_addr  = 32'h0000_0304;
        dm_wstrb = 4'h0;
        sample();
        checks++;
        if ({bus_req, dm_ack} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_idle got %b required 00", {bus_req, dm_ack});
        end
        tick();
        sample();
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0304}) begin
            errors++;
            $display("FAIL rmid_regrant got %0h required %0h", {bus_req, bus_addr}, {1'b1, 32'h0000_0304});
        end
        dm_req = 1'b0;
    endtask

    // Transaction-level reference: owner, age of the access and arbitration rules.
    task automatic test_random();
        int          m_owner;      // 0 none, 1 fetch, 2 data
        int          m_age;
        int          lim;
        bit          m_drop;
        bit          m_last_data;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_wstrb;
        bit          if_pend;
        bit          dm_pend;
        bit          fin;
        bit          tmo;
        bit          drop;
        bit          fetch_ok;
        logic        e_if_ack;
        logic        e_dm_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
        fix_wait    = -1;
        fix_data_en = 0;
        spur_en     = 1;
        do_reset();
        m_owner     = 0;
        m_age       = 0;
        m_drop      = 0;
        m_last_data = 0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        if_pend     = 0;
        dm_pend     = 0;
        for (int c = 0; c < 600; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend  = 1;
                dm_addr  = $urandom;
                dm_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dm_wdata = $urandom;
            end
            flush = ($urandom_range(0, 11) == 0);
            if (flush && if_pend) if_addr = $urandom & 32'hFFFF_FFFC;
            if_req = if_pend;
            dm_req = dm_pend;
            sample();
            fin = 0;
            tmo = 0;
            if (m_owner != 0) begin
                lim = (cur_wait < TO) ? cur_wait : TO - 1;
                fin = (m_age == lim);
                tmo = fin && (cur_wait >= TO);
            end
            drop       = m_drop || (m_owner == 1 && flush);
            e_if_ack   = fin && m_owner == 1 && !drop;
            e_dm_ack   = fin && m_owner == 2;
            e_if_rdata = (e_if_ack && !tmo) ? cur_data : 32'h0;
            e_dm_rdata = (e_dm_ack && !tmo) ? cur_data : 32'h0;
            checks++;
            if ({bus_req, bus_addr, bus_wstrb, bus_wdata} !== {m_owner != 0, m_addr, m_wstrb, m_wdata}) begin
                errors++;
                $display("FAIL rnd_bus cyc %0d got %0h required %0h", c,
                         {bus_req, bus_addr, bus_wstrb, bus_wdata}, {m_owner != 0, m_addr, m_wstrb, m_wdata});
            end
            checks++;
            if ({if_ack, if_rdata} !== {e_if_ack, e_if_rdata}) begin
                errors++;
                $display("FAIL rnd_if cyc %0d got %0h required %0h", c, {if_ack, if_rdata}, {e_if_ack, e_if_rdata});
            end
            checks++;
            if ({dm_ack, dm_rdata} !== {e_dm_ack, e_dm_rdata}) begin
                errors++;
                $display("FAIL rnd_dm cyc %0d got %0h required %0h", c, {dm_ack, dm_rdata}, {e_dm_ack, e_dm_rdata});
            end
            checks++;
            if ({stall_if, stall_mem, timeout} !== {if_req & ~e_if_ack, dm_req & ~e_dm_ack, tmo}) begin
                errors++;
                $display("FAIL rnd_stall_tmo cyc %0d got %b required %b", c,
                         {stall_if, stall_mem, timeout}, {if_req & ~e_if_ack, dm_req & ~e_dm_ack, tmo});
            end
            if (m_owner != 0) begin
                if (fin) begin
                    m_owner = 0;
                    m_drop  = 0;
                end else begin
                    m_age++;
                    if (m_owner == 1 && flush) m_drop = 1;
                end
            end else begin
                fetch_ok = if_req && !flush;
                if (dm_req && (!fetch_ok || !m_last_data)) begin
                    m_owner     = 2;
                    m_last_data = 1;
                    m_addr      = dm_addr;
                    m_wstrb     = dm_wstrb;
                    m_wdata     = dm_wdata;
                end else if (fetch_ok) begin
                    m_owner     = 1;
                    m_last_data = 0;
                    m_addr      = if_addr;
                    m_wstrb     = '0;
                    m_wdata     = '0;
                end
                m_age  = 0;
                m_drop = 0;
            end
            if (e_if_ack) if_pend = 0;
            if (e_dm_ack) dm_pend = 0;
            tick();
        end
        spur_en = 0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_addr  = '0;
        dm_wstrb = '0;
        dm_wdata = '0;
        flush    = 1'b0;
        test_reset();
        test_zero_wait();
        test_contention();
        test_fairness();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
